hazard_scoreboard: RTL

Parametrised stall unit for the pipelined MIPS core, placed beside the D stage. It keeps a per-stage scoreboard of in-flight register writes with countdown Tnew values and decides D-stage stalls by comparing them with the D instruction's Tuse. It owns an internal multiply/divide busy counter with configurable latency and blocks `eret` while an EPC write is in flight. Operand decode stays in the control unit; this block receives pre-decoded fields.

---
 rtl/hazard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// D-stage hazard bundle: pre-decoded operand/destination fields from the control
// unit going in, stall causes and HILO busy coming back.
interface hazard_if #(
  parameter int T_W = 3
) ();
  logic           d_valid;
  logic [4:0]     d_rs;
  logic [4:0]     d_rt;
  logic [T_W-1:0] d_tuse_rs;
  logic [T_W-1:0] d_tuse_rt;
  logic [4:0]     d_dst;
  logic [T_W-1:0] d_tnew;
  logic           d_md_start;
  logic           d_md_div;
  logic           d_md_use;
  logic           d_eret;
  logic           d_epc_wr;
  logic           flush;
  logic           stall;
  logic           stall_rs;
  logic           stall_rt;
  logic           stall_hilo;
  logic           stall_eret;
  logic           md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use, d_eret, d_epc_wr, flush,
    input  stall, stall_rs, stall_rt, stall_hilo, stall_eret, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use, d_eret, d_epc_wr, flush,
    output stall, stall_rs, stall_rt, stall_hilo, stall_eret, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// D-stage stall unit: per-stage scoreboard of in-flight writes with countdown Tnew,
// a multiply/divide busy counter and an eret-vs-EPC-write interlock.
module hazard_scoreboard #(
  parameter int DEPTH       = 2,
  parameter int T_W         = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset_n,
  hazard_if.slave hz
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX) + 1;

  typedef struct packed {
    logic           valid;
    logic [4:0]     dst;
    logic [T_W-1:0] tnew;
    logic           epc_wr;
    logic           md;
  } slot_t;

  slot_t           slots [DEPTH];
  logic [MD_W-1:0] md_cnt;
  logic            issue;

  logic           rs_found;
  logic           rt_found;
  logic [T_W-1:0] rs_tnew;
  logic [T_W-1:0] rt_tnew;
  logic           epc_pending;

  // Moving one stage down the pipe costs one cycle of Tnew, floored at zero.
  function automatic slot_t age(input slot_t s);
    slot_t r;
    r      = s;
    r.tnew = (s.tnew == '0) ? '0 : s.tnew - T_W'(1);
    return r;
  endfunction

  // Search oldest to youngest so the lowest-index match is the one that sticks.
  // NOTE: every variable written here gets a default first, otherwise a path that
  // skips the assignment would infer a latch.
  always_comb begin
    rs_found    = 1'b0;
    rt_found    = 1'b0;
    rs_tnew     = '0;
    rt_tnew     = '0;
    epc_pending = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slots[i].valid) begin
        if (hz.d_rs != 5'd0 && slots[i].dst == hz.d_rs) begin
          rs_found = 1'b1;
          rs_tnew  = slots[i].tnew;
        end
        if (hz.d_rt != 5'd0 && slots[i].dst == hz.d_rt) begin
          rt_found = 1'b1;
          rt_tnew  = slots[i].tnew;
        end
        if (slots[i].epc_wr) begin
          epc_pending = 1'b1;
        end
      end
    end
  end

  assign hz.stall_rs   = hz.d_valid && rs_found && (hz.d_tuse_rs < rs_tnew);
  assign hz.stall_rt   = hz.d_valid && rt_found && (hz.d_tuse_rt < rt_tnew);
  assign hz.md_busy    = (md_cnt != '0);
  assign hz.stall_hilo = hz.d_valid && hz.d_md_use && hz.md_busy;
  assign hz.stall_eret = hz.d_valid && hz.d_eret && epc_pending;
  assign hz.stall      = hz.stall_rs || hz.stall_rt || hz.stall_hilo || hz.stall_eret;

  assign issue = hz.d_valid && !hz.stall && !hz.flush;

  // NOTE: the scoreboard slots are state that gates stalls, so unlike a data RAM
  // they must be cleared by reset; a stale valid bit would freeze D.
  // NOTE: non-blocking assignments throughout so every slot samples its neighbour's
  // pre-edge value and the shift does not ripple within one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      md_cnt <= '0;
    end else begin
      if (hz.flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          slots[i] <= '0;
        end
      end else begin
        if (issue) begin
          slots[0] <= '{valid: 1'b1, dst: hz.d_dst, tnew: hz.d_tnew,
                        epc_wr: hz.d_epc_wr, md: hz.d_md_start};
        end else begin
          slots[0] <= '0;
        end
        for (int i = 1; i < DEPTH; i++) begin
          slots[i] <= age(slots[i-1]);
        end
      end

      // A start op still sitting in E is squashed by flush; once past E it commits.
      if (issue && hz.d_md_start) begin
        md_cnt <= hz.d_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
      end else if (hz.flush && slots[0].valid && slots[0].md) begin
        md_cnt <= '0;
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - MD_W'(1);
      end
    end
  end

endmodule
